cdc_sync_filter: RTL and testbench

- Multi-channel asynchronous-input conditioner for the AFU control plane.
- Each of NUM_CH single-bit inputs passes through a NUM_SYNC-stage synchronizer, then a per-channel consecutive-sample glitch filter.
- Outputs are a filtered level plus one-cycle rise/fall pulses per channel, all in the clk domain.
- Used for status pins, straps and slow handshakes from foreign clock domains.

---
 rtl/cdc_glitch_filter.sv | 86 ++++++++
 rtl/cdc_sync_filter.sv | 86 ++++++++
 tb/tb_cdc_sync_filter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cdc_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_glitch_filter
// Description : Single-channel consecutive-sample glitch filter. The level
//               changes only after FILTER_CNT consecutive samples that differ
//               from it. A bypass input, or FILTER_CNT of 0, makes the level
//               follow the sample directly. Registered one-cycle rise and fall
//               pulses mark every level change.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_glitch_filter #(
    parameter int   FILTER_CNT = 4,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sample,
    input  logic i_bypass,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_event_nxt
);

    localparam int C_CNT_W = (FILTER_CNT < 1) ? 1 : $clog2(FILTER_CNT + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST =
        C_CNT_W'((FILTER_CNT > 0) ? (FILTER_CNT - 1) : 0);
    localparam logic C_NO_FILTER = (FILTER_CNT == 0);

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;

    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               w_level_nxt;
    logic               w_rise_nxt;
    logic               w_fall_nxt;
    logic               w_bypass;

    assign w_bypass = C_NO_FILTER | i_bypass;

    // Next level and counter: bypass follows the sample and drops any count;
    // otherwise a differing sample advances the count and the last one commits.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        if (w_bypass) begin
            w_cnt_nxt   = '0;
            w_level_nxt = i_sample;
        end else if (i_sample == r_level) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == C_CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_level_nxt = i_sample;
        end else begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
        w_rise_nxt = w_level_nxt & ~r_level;
        w_fall_nxt = ~w_level_nxt & r_level;
    end

    // State registers; pulses are registered alongside the level they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= RESET_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    assign o_level     = r_level;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    // Unregistered pulse request, so the top can register o_change in the
    // same cycle as the per-channel pulses.
    assign o_event_nxt = (w_rise_nxt | w_fall_nxt) & ~reset;

endmodule
`default_nettype wire

// File: rtl/cdc_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_sync_filter
// Description : Multi-channel asynchronous-input conditioner. Each channel is
//               a NUM_SYNC-stage synchronizer followed by a glitch filter,
//               giving a filtered level plus rise/fall pulses in clk domain.
//               Channels are independent; not for multi-bit buses.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_sync_filter #(
    parameter int                NUM_CH     = 4,
    parameter int                NUM_SYNC   = 2,
    parameter int                FILTER_CNT = 4,
    parameter logic [NUM_CH-1:0] RESET_VAL  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] i_async,
    input  logic [NUM_CH-1:0] i_bypass,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_rise,
    output logic [NUM_CH-1:0] o_fall,
    output logic              o_change
);

    // Depth is clamped to 2..4 stages.
    localparam int C_SYNC_DEPTH = (NUM_SYNC < 2) ? 2 :
                                  (NUM_SYNC > 4) ? 4 : NUM_SYNC;

    (* ASYNC_REG = "TRUE" *)
    (* dont_touch = "true" *)
    (* preserve *)
    (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED" *)
    logic [NUM_CH-1:0] r_sync [C_SYNC_DEPTH];

    logic [NUM_CH-1:0] w_sync_out;
    logic [NUM_CH-1:0] w_event_nxt;
    logic              r_change;

    // Synchronizer chain: plain flop-to-flop, no logic between stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < C_SYNC_DEPTH; k++) begin
                r_sync[k] <= RESET_VAL;
            end
        end else begin
            r_sync[0] <= i_async;
            for (int k = 1; k < C_SYNC_DEPTH; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync_out = r_sync[C_SYNC_DEPTH-1];

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            cdc_glitch_filter #(
                .FILTER_CNT (FILTER_CNT),
                .RESET_VAL  (RESET_VAL[ch])
            ) u_filter (
                .clk         (clk),
                .reset       (reset),
                .i_sample    (w_sync_out[ch]),
                .i_bypass    (i_bypass[ch]),
                .o_level     (o_level[ch]),
                .o_rise      (o_rise[ch]),
                .o_fall      (o_fall[ch]),
                .o_event_nxt (w_event_nxt[ch])
            );
        end
    endgenerate

    // Any-channel change flag, aligned with the per-channel pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_change <= 1'b0;
        end else begin
            r_change <= |w_event_nxt;
        end
    end

    assign o_change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_cdc_sync_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_sync_filter
// Description : Self-checking bench for cdc_sync_filter. A vector table drives
//               the main instance; hand sequences cover bypass, reset in the
//               middle of a count and parameter corners (NUM_SYNC 3 and 1,
//               FILTER_CNT 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_sync_filter;

    typedef struct {
        logic [3:0] a;
        logic [3:0] byp;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] a0, b0, a1, a2, b_none;

    logic [3:0] lv0, ri0, fa0;  logic ch0;
    logic [3:0] lv1, ri1, fa1;  logic ch1;
    logic [3:0] lv2, ri2, fa2;  logic ch2;
    logic [3:0] lv3, ri3, fa3;  logic ch3;

    int checks = 0;
    int failures = 0;

    vec_t       tbl [24];
    logic [10:0] u;
    logic       e_cur, e_prv;

    always #5 clk = ~clk;

    cdc_sync_filter #(.NUM_CH(4), .NUM_SYNC(2), .FILTER_CNT(4), .RESET_VAL(4'b0000)) dut0 (
        .clk(clk), .reset(reset), .i_async(a0), .i_bypass(b0),
        .o_level(lv0), .o_rise(ri0), .o_fall(fa0), .o_change(ch0));

    cdc_sync_filter #(.NUM_CH(4), .NUM_SYNC(2), .FILTER_CNT(4), .RESET_VAL(4'b0101)) dut1 (
        .clk(clk), .reset(reset), .i_async(a1), .i_bypass(b_none),
        .o_level(lv1), .o_rise(ri1), .o_fall(fa1), .o_change(ch1));

    cdc_sync_filter #(.NUM_CH(4), .NUM_SYNC(3), .FILTER_CNT(0), .RESET_VAL(4'b0000)) dut2 (
        .clk(clk), .reset(reset), .i_async(a2), .i_bypass(b_none),
        .o_level(lv2), .o_rise(ri2), .o_fall(fa2), .o_change(ch2));

    cdc_sync_filter #(.NUM_CH(4), .NUM_SYNC(1), .FILTER_CNT(0), .RESET_VAL(4'b0000)) dut3 (
        .clk(clk), .reset(reset), .i_async(a2), .i_bypass(b_none),
        .o_level(lv3), .o_rise(ri3), .o_fall(fa3), .o_change(ch3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_d0(input string tag, input logic [3:0] l, input logic [3:0] r,
                          input logic [3:0] f, input logic c);
        chk({tag, " dut0 level"},  lv0, l);
        chk({tag, " dut0 rise"},   ri0, r);
        chk({tag, " dut0 fall"},   fa0, f);
        chk({tag, " dut0 change"}, ch0, c);
    endtask

    initial begin
        // Vector table for dut0; entry i is applied before edge i+1.
        for (int i = 0; i < 24; i++) begin
            tbl[i].byp  = 4'b0000;
            tbl[i].a    = (i + 1 <= 3)  ? 4'b1011 :
                          (i + 1 <= 8)  ? 4'b1001 :
                          (i + 1 <= 12) ? 4'b1010 :
                          (i + 1 <= 16) ? 4'b1000 : 4'b0001;
            tbl[i].lvl  = (i + 1 <= 5)  ? 4'b0000 :
                          (i + 1 <= 13) ? 4'b1001 :
                          (i + 1 <= 17) ? 4'b1010 :
                          (i + 1 <= 21) ? 4'b1000 : 4'b0001;
            tbl[i].rise = 4'b0000;
            tbl[i].fall = 4'b0000;
            tbl[i].chg  = 1'b0;
        end
        tbl[5].rise  = 4'b1001; tbl[5].chg  = 1'b1;
        tbl[13].rise = 4'b0010; tbl[13].fall = 4'b0001; tbl[13].chg = 1'b1;
        tbl[17].fall = 4'b0010; tbl[17].chg = 1'b1;
        tbl[21].rise = 4'b0001; tbl[21].fall = 4'b1000; tbl[21].chg = 1'b1;

        a0 = 4'b0000; b0 = 4'b0000; a1 = 4'b0101; a2 = 4'b0000; b_none = 4'b0000;
        reset = 1'b1;

        // Reset held three cycles, then 20 idle cycles.
        repeat (3) begin
            step();
            chk_d0("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
            chk("reset dut1 level", lv1, 4'b0101);
            chk("reset dut1 pulses", {ri1, fa1, 3'b000, ch1}, 12'h000);
        end
        reset = 1'b0;
        repeat (20) begin
            step();
            chk("idle dut1 level", lv1, 4'b0101);
            chk("idle dut1 pulses", {ri1, fa1, 3'b000, ch1}, 12'h000);
            chk("idle dut0 level", lv0, 4'b0000);
        end

        // Table: clean rise, glitch rejection, wide pulse, simultaneous events.
        for (int i = 0; i < 24; i++) begin
            a0 = tbl[i].a;
            b0 = tbl[i].byp;
            step();
            chk_d0("table", tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].chg);
        end

        // Bypass on channel 2, toggling every two cycles; latency 3 edges.
        u = 11'b00001100110;
        for (int n = 1; n <= 10; n++) begin
            a0 = {1'b0, u[n], 2'b01};
            b0 = 4'b0100;
            step();
            e_cur = (n >= 3) ? u[n-2] : 1'b0;
            e_prv = (n >= 4) ? u[n-3] : 1'b0;
            chk_d0("bypass", {1'b0, e_cur, 2'b01}, {1'b0, e_cur & ~e_prv, 2'b00},
                   {1'b0, ~e_cur & e_prv, 2'b00}, e_cur ^ e_prv);
        end

        // Filter counts on ch2, then bypass asserts mid-count and updates at once.
        a0 = 4'b0101; b0 = 4'b0000;
        repeat (4) begin
            step();
            chk_d0("midbyp count", 4'b0001, 4'b0000, 4'b0000, 1'b0);
        end
        b0 = 4'b0100;
        step();
        chk_d0("midbyp assert", 4'b0101, 4'b0100, 4'b0000, 1'b1);
        b0 = 4'b0000; a0 = 4'b0001;
        for (int n = 6; n <= 11; n++) begin
            step();
            if (n < 11) chk_d0("midbyp hold", 4'b0101, 4'b0000, 4'b0000, 1'b0);
            else        chk_d0("midbyp fall", 4'b0001, 4'b0000, 4'b0100, 1'b1);
        end

        // Reset while ch3 is at filter count 2.
        a0 = 4'b1001;
        repeat (4) begin
            step();
            chk_d0("rstmid count", 4'b0001, 4'b0000, 4'b0000, 1'b0);
        end
        reset = 1'b1;
        step();
        chk_d0("rstmid reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        reset = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            step();
            if (n < 6)       chk_d0("rstmid wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
            else if (n == 6) chk_d0("rstmid rise", 4'b1001, 4'b1001, 4'b0000, 1'b1);
            else             chk_d0("rstmid after", 4'b1001, 4'b0000, 4'b0000, 1'b0);
        end

        // Parameter corners: NUM_SYNC=3 and NUM_SYNC=1 (clamped to 2), unfiltered.
        a2 = 4'b1000;
        repeat (6) step();
        chk("corner pre dut2 level", lv2, 4'b1000);
        chk("corner pre dut3 level", lv3, 4'b1000);
        chk("corner pre pulses", {ri2, fa2, ri3, fa3}, 16'h0000);
        a2 = 4'b0001;
        for (int n = 1; n <= 5; n++) begin
            step();
            chk("corner dut3 level", lv3, (n >= 3) ? 4'b0001 : 4'b1000);
            chk("corner dut3 rise",  ri3, (n == 3) ? 4'b0001 : 4'b0000);
            chk("corner dut3 fall",  fa3, (n == 3) ? 4'b1000 : 4'b0000);
            chk("corner dut3 change", ch3, (n == 3) ? 1'b1 : 1'b0);
            chk("corner dut2 level", lv2, (n >= 4) ? 4'b0001 : 4'b1000);
            chk("corner dut2 rise",  ri2, (n == 4) ? 4'b0001 : 4'b0000);
            chk("corner dut2 fall",  fa2, (n == 4) ? 4'b1000 : 4'b0000);
            chk("corner dut2 change", ch2, (n == 4) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
